// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream input plus memory-write and boot-status outputs of the boot loader
interface boot_loader_if #(parameter int D_DEPTH_WIDTH = 10);
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    logic mem_en;
    logic [3:0] mem_wr_mask;
    logic [D_DEPTH_WIDTH-1:0] mem_addr;
    logic [31:0] mem_data;
    logic boot_active;
    logic cpu_rst;
    logic done;
    logic error;
    modport master (
        output in_data, in_valid,
        input in_ready, mem_en, mem_wr_mask, mem_addr, mem_data, boot_active, cpu_rst, done, error
    );
    modport slave (
        input in_data, in_valid,
        output in_ready, mem_en, mem_wr_mask, mem_addr, mem_data, boot_active, cpu_rst, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: loads a framed little-endian image into memory and holds the core in reset until the XOR checksum verifies
module boot_loader #(
    parameter int D_DEPTH_WIDTH = 10,
    parameter int BASE_ADDR = 0,
    parameter int unsigned TIMEOUT = 65535
) (
    input logic clk,
    input logic rst,
    boot_loader_if.slave bus
);
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERROR} state_t;
    localparam logic [31:0] LIMIT = (32'd1 << D_DEPTH_WIDTH) - 32'(BASE_ADDR);
    state_t state;
    logic [15:0] n;
    logic [15:0] word_idx;
    logic [1:0] byte_idx;
    logic [7:0] chk;
    logic [23:0] word;
    logic [31:0] idle;
    logic [15:0] n_full;
    logic acc;
    logic waiting;
    logic expired;
    assign acc = bus.in_valid && bus.in_ready;
    assign waiting = state inside {LEN_HI, DATA, CHK};
    assign expired = TIMEOUT != 0 && waiting && !acc && idle + 32'd1 == TIMEOUT;
    assign n_full = {bus.in_data, n[7:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN_LO;
            n <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            chk <= '0;
            word <= '0;
            idle <= '0;
            bus.in_ready <= 1'b1;
            bus.mem_en <= 1'b0;
            bus.mem_wr_mask <= 4'h0;
            bus.mem_addr <= D_DEPTH_WIDTH'(BASE_ADDR);
            bus.mem_data <= '0;
            bus.boot_active <= 1'b1;
            bus.cpu_rst <= 1'b1;
            bus.done <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            bus.mem_en <= 1'b0;
            bus.mem_wr_mask <= 4'h0;
            if (acc) idle <= '0;
            else if (waiting) idle <= idle + 32'd1;
            case (state)
                LEN_LO: if (acc) begin
                    n[7:0] <= bus.in_data;
                    state <= LEN_HI;
                end
                LEN_HI: if (acc) begin
                    n[15:8] <= bus.in_data;
                    if (32'(n_full) > LIMIT) begin
                        state <= ERROR;
                        bus.error <= 1'b1;
                        bus.in_ready <= 1'b0;
                    end else begin
                        state <= n_full == 16'd0 ? CHK : DATA;
                    end
                end
                DATA: if (acc) begin
                    word <= {bus.in_data, word[23:8]};
                    chk <= chk ^ bus.in_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state <= WRITE;
                        bus.in_ready <= 1'b0;
                        bus.mem_en <= 1'b1;
                        bus.mem_wr_mask <= 4'hF;
                        bus.mem_addr <= D_DEPTH_WIDTH'(32'(BASE_ADDR) + 32'(word_idx));
                        bus.mem_data <= {bus.in_data, word};
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    bus.in_ready <= 1'b1;
                    state <= word_idx + 16'd1 == n ? CHK : DATA;
                end
                CHK: if (acc) begin
                    bus.in_ready <= 1'b0;
                    if (bus.in_data == chk) begin
                        state <= DONE;
                        bus.done <= 1'b1;
                        bus.cpu_rst <= 1'b0;
                        bus.boot_active <= 1'b0;
                        bus.mem_addr <= '0;
                        bus.mem_data <= '0;
                    end else begin
                        state <= ERROR;
                        bus.error <= 1'b1;
                    end
                end
                default: ;
            endcase
            // a stalled sender aborts the frame; an accepted byte on the same edge wins
            if (expired) begin
                state <= ERROR;
                bus.error <= 1'b1;
                bus.in_ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized and directed frames checked against a byte-level image model
module tb_boot_loader;
    localparam int AW = 10;
    localparam int BASE = 0;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [AW+31:0] wq[$];
    bit prev_en = 1'b0;

    always #5 clk = ~clk;

    boot_loader_if #(.D_DEPTH_WIDTH(AW)) bus();
    boot_loader #(.D_DEPTH_WIDTH(AW), .BASE_ADDR(BASE), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.mem_wr_mask !== (bus.mem_en ? 4'hF : 4'h0)) begin
                failures++;
                $display("FAIL mask: mem_en=%b mem_wr_mask=%h", bus.mem_en, bus.mem_wr_mask);
            end
            if (bus.mem_en === 1'b1) begin
                wq.push_back({bus.mem_addr, bus.mem_data});
                checks++;
                if (prev_en || bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL write_pulse: prev_en=%b in_ready=%b, required 0 0", prev_en, bus.in_ready);
                end
            end
        end
        prev_en = bus.mem_en === 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wq.delete();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_data = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_stall: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [7:0] q[$], input int max_gap);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        logic [AW+31:0] exp_w[$];
        bit exp_done;
        wq.delete();
        x = 8'h00;
        n = int'(q[0]) + 256 * int'(q[1]);
        if (n > (1 << AW) - BASE) begin
            exp_done = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = 32'h0;
                for (int k = 0; k < 4; k++) begin
                    w |= 32'(q[2+4*i+k]) << (8 * k);
                    x ^= q[2+4*i+k];
                end
                exp_w.push_back({AW'(BASE + i), w});
            end
            exp_done = q[2+4*n] == x;
        end
        foreach (q[i]) begin
            send_byte(q[i]);
            if (i < q.size() - 1) repeat ($urandom_range(max_gap)) @(negedge clk);
        end
        checks++;
        if (wq.size() != exp_w.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wq.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                checks++;
                if (wq[i] !== exp_w[i]) begin
                    failures++;
                    $display("FAIL %s write%0d: got addr=%0d data=%h, required addr=%0d data=%h", name, i,
                             wq[i][AW+31:32], wq[i][31:0], exp_w[i][AW+31:32], exp_w[i][31:0]);
                end
            end
        end
        checks++;
        if (bus.done !== exp_done || bus.error !== !exp_done) begin
            failures++;
            $display("FAIL %s status: done=%b error=%b, required done=%b error=%b", name, bus.done, bus.error, exp_done, !exp_done);
        end
        checks++;
        if (bus.cpu_rst !== !exp_done || bus.boot_active !== !exp_done) begin
            failures++;
            $display("FAIL %s handover: cpu_rst=%b boot_active=%b, required %b %b", name, bus.cpu_rst, bus.boot_active, !exp_done, !exp_done);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s in_ready_terminal: got %b, required 0", name, bus.in_ready);
        end
        if (exp_done) begin
            checks++;
            if (bus.mem_data !== 32'h0 || bus.mem_addr !== '0) begin
                failures++;
                $display("FAIL %s done_mem: addr=%0d data=%h, required 0 0", name, bus.mem_addr, bus.mem_data);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mem_en !== 1'b0 || bus.mem_wr_mask !== 4'h0) begin
            failures++;
            $display("FAIL reset_port: in_ready=%b mem_en=%b mask=%h, required 1 0 0", bus.in_ready, bus.mem_en, bus.mem_wr_mask);
        end
        checks++;
        if (bus.mem_addr !== AW'(BASE) || bus.mem_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: addr=%0d data=%h, required %0d 0", bus.mem_addr, bus.mem_data, BASE);
        end
        checks++;
        if (bus.boot_active !== 1'b1 || bus.cpu_rst !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: boot_active=%b cpu_rst=%b done=%b error=%b, required 1 1 0 0",
                     bus.boot_active, bus.cpu_rst, bus.done, bus.error);
        end
    endtask

    task automatic test_known_frame();
        logic [7:0] f[$];
        f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        do_reset();
        run_frame("known", f, 2);
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(f[i]);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== AW'(0) || bus.mem_data !== 32'h00100513 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL write_latency: en=%b addr=%0d data=%h in_ready=%b, required 1 0 00100513 0",
                     bus.mem_en, bus.mem_addr, bus.mem_data, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.mem_en !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_one_cycle: en=%b in_ready=%b, required 0 1", bus.mem_en, bus.in_ready);
        end
        for (int i = 6; i < 10; i++) send_byte(f[i]);
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== AW'(1) || bus.mem_data !== 32'h00200593) begin
            failures++;
            $display("FAIL second_write: en=%b addr=%0d data=%h, required 1 1 00200593", bus.mem_en, bus.mem_addr, bus.mem_data);
        end
        send_byte(f[10]);
        checks++;
        if (bus.done !== 1'b1 || bus.cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL done_edge: done=%b cpu_rst=%b, required 1 0", bus.done, bus.cpu_rst);
        end
    endtask

    task automatic test_empty_frame();
        logic [7:0] f[$];
        f = '{8'h00, 8'h00, 8'h00};
        do_reset();
        run_frame("empty", f, 1);
    endtask

    task automatic test_bad_chk();
        logic [7:0] f[$];
        f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};
        do_reset();
        run_frame("bad_chk", f, 1);
        bus.in_data = 8'h55;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.error !== 1'b1) begin
                failures++;
                $display("FAIL error_hold: in_ready=%b error=%b, required 0 1", bus.in_ready, bus.error);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (wq.size() != 2) begin
            failures++;
            $display("FAIL error_no_write: writes=%0d, required 2", wq.size());
        end
    endtask

    task automatic test_too_long();
        logic [7:0] f[$];
        f = '{8'h01, 8'h04};
        do_reset();
        run_frame("too_long", f, 0);
        do_reset();
        send_byte(8'h00);
        send_byte(8'h04);
        checks++;
        if (bus.error !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL max_len: error=%b in_ready=%b, required 0 1", bus.error, bus.in_ready);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (100) @(negedge clk);
        checks++;
        if (bus.error !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_len_lo: error=%b in_ready=%b, required 0 1", bus.error, bus.in_ready);
        end
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        repeat (15) @(negedge clk);
        checks++;
        if (bus.error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: error=%b after 15 idle, required 0", bus.error);
        end
        send_byte(8'h05);
        repeat (15) @(negedge clk);
        checks++;
        if (bus.error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: error=%b after byte+15 idle, required 0", bus.error);
        end
        @(negedge clk);
        checks++;
        if (bus.error !== 1'b1 || bus.in_ready !== 1'b0 || bus.cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fire: error=%b in_ready=%b cpu_rst=%b, required 1 0 1", bus.error, bus.in_ready, bus.cpu_rst);
        end
    endtask

    task automatic test_rst_mid_frame();
        logic [7:0] f[$];
        f = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(f[i]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_frame("rst_mid", f, 1);
    endtask

    task automatic test_random();
        logic [7:0] f[$];
        logic [7:0] x;
        int n;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 7);
            f.delete();
            f.push_back(8'(n));
            f.push_back(8'h00);
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                f.push_back(8'($urandom));
                x ^= f[f.size()-1];
            end
            if ($urandom_range(3) == 0) x ^= 8'($urandom_range(1, 255));
            f.push_back(x);
            do_reset();
            run_frame($sformatf("random%0d", r), f, 3);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        test_reset();
        test_known_frame();
        test_reset();
        test_empty_frame();
        test_bad_chk();
        test_too_long();
        test_timeout();
        test_rst_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
